// File: rtl/uart_pkg.sv
// ============================================================================
// uart_pkg
// Shared UART types and helpers for the RX and TX stages.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_pkg;

  // Receiver frame states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_e;

  // Core clock cycles per serial bit (integer division)
  function automatic int bit_cycles(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sync_fifo.sv
// ============================================================================
// sync_fifo
// Show-ahead synchronous FIFO with occupancy counter and overflow indication.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           push_i,
  input  logic [WIDTH-1:0]               wdata_i,
  input  logic                           pop_i,
  output logic [WIDTH-1:0]               rdata_o,
  output logic                           full_o,
  output logic                           empty_o,
  output logic [$clog2(DEPTH+1)-1:0]     level_o,
  output logic                           overflow_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [LVL_W-1:0] level_q;
  logic [LVL_W-1:0] level_d;
  logic             do_push;
  logic             do_pop;

  assign full_o   = (level_q == LVL_W'(DEPTH));
  assign empty_o  = (level_q == '0);
  assign do_pop   = pop_i & ~empty_o;
  // A pop frees the slot in the same cycle, so a push into a full FIFO is fine then
  assign do_push  = push_i & (~full_o | do_pop);
  assign overflow_o = push_i & full_o & ~pop_i;
  assign rdata_o  = mem_q[rd_ptr_q];
  assign level_o  = level_q;

  // Occupancy follows the net effect of push and pop
  always_comb begin
    level_d = level_q;
    if (do_push && !do_pop) begin
      level_d = level_q + LVL_W'(1);
    end else if (do_pop && !do_push) begin
      level_d = level_q - LVL_W'(1);
    end
  end

  // Storage, pointers (wrap naturally modulo DEPTH) and level register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= wdata_i;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      level_q <= level_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/uart_rx_buffered.sv
// ============================================================================
// uart_rx_buffered
// 8N1 UART receiver with input synchronizer, deframing FSM and receive FIFO.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx_buffered
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 25_000_000,
  parameter int BAUDRATE   = 115200,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic                              ser_rx_i,
  output logic [7:0]                        rdata_o,
  output logic                              rvalid_o,
  input  logic                              rready_i,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   level_o,
  output logic                              frame_err_o,
  output logic                              overrun_o
);

  localparam int BIT_CYCLES = bit_cycles(CLK_FREQ, BAUDRATE);
  localparam int HALF       = BIT_CYCLES / 2;
  localparam int CNT_W      = $clog2(BIT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(HALF - 1);

  if (BIT_CYCLES < 4) begin : g_chk_bit_cycles
    $fatal(1, "uart_rx_buffered: BIT_CYCLES must be >= 4");
  end
  if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_chk_depth
    $fatal(1, "uart_rx_buffered: FIFO_DEPTH must be a power of two >= 2");
  end

  logic            rx_meta_q;
  logic            rx_s_q;
  logic [1:0]      settle_q;
  rx_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      shreg_q, shreg_d;
  logic            armed_q, armed_d;
  logic            frame_err_q, frame_err_d;
  logic            overrun_q;
  logic            push;
  logic            fifo_full;
  logic            fifo_empty;
  logic            fifo_overflow;

  // Synchronizer, settle tracker and all FSM-side registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rx_meta_q   <= 1'b1;
      rx_s_q      <= 1'b1;
      settle_q    <= 2'b00;
      state_q     <= IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      shreg_q     <= '0;
      armed_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      rx_meta_q   <= ser_rx_i;
      rx_s_q      <= rx_meta_q;
      settle_q    <= {settle_q[0], 1'b1};
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shreg_q     <= shreg_d;
      armed_q     <= armed_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= fifo_overflow;
    end
  end

  // Deframing: start validation, mid-bit data sampling, stop check
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    shreg_d     = shreg_q;
    armed_d     = armed_q;
    frame_err_d = 1'b0;
    push        = 1'b0;
    unique case (state_q)
      IDLE: begin
        // The synchronizer holds its reset value for two cycles after reset;
        // only arm once rx_s really reflects the pin, so a line held low
        // through reset release cannot start a frame.
        if (rx_s_q && settle_q[1]) begin
          armed_d = 1'b1;
        end
        if (armed_q && !rx_s_q) begin
          state_d = START;
          cnt_d   = '0;
        end
      end
      START: begin
        if (cnt_q == CNT_MID) begin
          cnt_d = '0;
          if (!rx_s_q) begin
            state_d = DATA;
            idx_d   = '0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d          = '0;
          shreg_d[idx_q] = rx_s_q;
          if (idx_q == 3'd7) begin
            state_d = STOP;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
          armed_d = 1'b0;
          if (rx_s_q) begin
            push = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .push_i     (push),
    .wdata_i    (shreg_q),
    .pop_i      (rready_i),
    .rdata_o    (rdata_o),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .level_o    (level_o),
    .overflow_o (fifo_overflow)
  );

  assign rvalid_o    = ~fifo_empty;
  assign frame_err_o = frame_err_q;
  assign overrun_o   = overrun_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_buffered.sv
// ============================================================================
// tb_uart_rx_buffered
// Self-checking bench: table-driven frames, hand-written corner sequences and
// randomized traffic against a queue-based reference model.
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_uart_rx_buffered;

  localparam int CLK_FREQ   = 25_000_000;
  localparam int BAUDRATE   = 115200;
  localparam int FIFO_DEPTH = 8;
  localparam int BIT        = CLK_FREQ / BAUDRATE;  // 217
  localparam int IDLE_GAP   = 8;
  // Start edge driven -> byte / frame error visible: 3 cycles to reach START,
  // 108 to mid start bit, 9 bit periods to mid stop bit.
  localparam int PUSH_LAT   = 3 + BIT / 2 + 9 * BIT;

  logic       clk = 1'b0;
  logic       rst;
  logic       ser;
  logic       rdy_man;
  logic       rnd_en;
  logic       rnd_rdy;
  logic       rready;
  logic [7:0] rdata;
  logic       rvalid;
  logic [3:0] level;
  logic       frame_err;
  logic       overrun;

  assign rready = rnd_en ? rnd_rdy : rdy_man;

  uart_rx_buffered #(
    .CLK_FREQ   (CLK_FREQ),
    .BAUDRATE   (BAUDRATE),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .ser_rx_i    (ser),
    .rdata_o     (rdata),
    .rvalid_o    (rvalid),
    .rready_i    (rready),
    .level_o     (level),
    .frame_err_o (frame_err),
    .overrun_o   (overrun)
  );

  always #5 clk = ~clk;

  // ---------------- monitor ----------------
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    rnd_rdy = 1'($urandom_range(0, 1));
  end

  logic [7:0] recv_mem [0:255];
  int recv_n = 0, fe_n = 0, ov_n = 0, rv_n = 0, fe_cyc = 0;
  int lvl_max = 0, lvl_min = 0, clr_gen = 0, seen_gen = 0;

  always @(negedge clk) begin
    if (clr_gen != seen_gen) begin
      seen_gen = clr_gen;
      lvl_max  = int'(level);
      lvl_min  = int'(level);
    end else begin
      if (int'(level) > lvl_max) lvl_max = int'(level);
      if (int'(level) < lvl_min) lvl_min = int'(level);
    end
    if (rvalid) rv_n++;
    if (rvalid && rready && recv_n < 256) begin
      recv_mem[recv_n] = rdata;
      recv_n++;
    end
    if (frame_err) begin
      fe_n++;
      fe_cyc = cyc;
    end
    if (overrun) ov_n++;
  end

  // ---------------- checking ----------------
  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  int frame_start = 0;

  task automatic send_frame(input logic [7:0] b, input logic stop);
    @(posedge clk); #1;
    frame_start = cyc;
    ser = 1'b0;
    repeat (BIT) @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      ser = b[i];
      repeat (BIT) @(posedge clk);
      #1;
    end
    ser = stop;
    repeat (BIT) @(posedge clk);
    #1;
    ser = 1'b1;
    repeat (IDLE_GAP) @(posedge clk);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         exp_push;
    int         exp_fe;
  } vec_t;

  vec_t vecs [4];
  logic [7:0] exp_q [$];

  initial begin
    int r0, f0, o0, v0, bad;
    logic [7:0] b;
    logic       s;

    vecs[0] = '{8'h68, 1'b1, 1, 0};
    vecs[1] = '{8'h55, 1'b0, 0, 1};
    vecs[2] = '{8'hFF, 1'b1, 1, 0};
    vecs[3] = '{8'h00, 1'b1, 1, 0};

    rst = 1'b1; ser = 1'b1; rdy_man = 1'b0; rnd_en = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset rdata", int'(rdata), 0);
    check("reset rvalid", int'(rvalid), 0);
    check("reset level", int'(level), 0);
    check("reset frame_err", int'(frame_err), 0);
    check("reset overrun", int'(overrun), 0);
    repeat (10) @(posedge clk);

    // Table-driven single frames with consumer always ready
    rdy_man = 1'b1;
    foreach (vecs[k]) begin
      r0 = recv_n; f0 = fe_n; o0 = ov_n; v0 = rv_n;
      clr_gen++;
      send_frame(vecs[k].data, vecs[k].stop);
      repeat (4) @(posedge clk);
      @(negedge clk);
      check($sformatf("vec%0d pushes", k), recv_n - r0, vecs[k].exp_push);
      if (vecs[k].exp_push == 1)
        check($sformatf("vec%0d byte", k), int'(recv_mem[r0]), int'(vecs[k].data));
      check($sformatf("vec%0d rvalid cycles", k), rv_n - v0, vecs[k].exp_push);
      check($sformatf("vec%0d level max", k), lvl_max, vecs[k].exp_push);
      check($sformatf("vec%0d frame_err pulses", k), fe_n - f0, vecs[k].exp_fe);
      check($sformatf("vec%0d overrun pulses", k), ov_n - o0, 0);
      check($sformatf("vec%0d level end", k), int'(level), 0);
      if (vecs[k].exp_fe == 1) begin
        check($sformatf("vec%0d frame_err latency ok (lat=%0d)", k, fe_cyc - frame_start),
              int'((fe_cyc - frame_start) >= PUSH_LAT - 4 && (fe_cyc - frame_start) <= PUSH_LAT + 4), 1);
      end
    end

    // Start-bit glitch: 50 low cycles must be rejected silently
    r0 = recv_n; f0 = fe_n; o0 = ov_n;
    @(posedge clk); #1 ser = 1'b0;
    repeat (50) @(posedge clk);
    #1 ser = 1'b1;
    repeat (3 * BIT) @(posedge clk);
    @(negedge clk);
    check("glitch pushes", recv_n - r0, 0);
    check("glitch frame_err", fe_n - f0, 0);
    check("glitch level", int'(level), 0);
    send_frame(8'h5A, 1'b1);
    repeat (4) @(posedge clk);
    check("after glitch pushes", recv_n - r0, 1);
    check("after glitch byte", int'(recv_mem[r0]), 'h5A);

    // Fill with consumer stalled; ninth byte overruns
    rdy_man = 1'b0;
    r0 = recv_n; o0 = ov_n; f0 = fe_n;
    for (int i = 0; i < 8; i++) send_frame(8'(i), 1'b1);
    @(negedge clk);
    check("fill level", int'(level), 8);
    check("fill overrun before 9th", ov_n - o0, 0);
    send_frame(8'h08, 1'b1);
    @(negedge clk);
    check("overrun pulses", ov_n - o0, 1);
    check("overrun level", int'(level), 8);
    check("overrun frame_err", fe_n - f0, 0);

    // Full FIFO, pop exactly in the push cycle of 0xA5
    o0 = ov_n;
    clr_gen++;
    fork
      send_frame(8'hA5, 1'b1);
      begin
        @(posedge clk);
        repeat (PUSH_LAT - 1) @(posedge clk);
        #1 rdy_man = 1'b1;
        @(posedge clk);
        #1 rdy_man = 1'b0;
      end
    join
    @(negedge clk);
    check("full push+pop level", int'(level), 8);
    check("full push+pop level min", lvl_min, 8);
    check("full push+pop overrun", ov_n - o0, 0);
    check("full push+pop popped count", recv_n - r0, 1);
    rdy_man = 1'b1;
    repeat (20) @(posedge clk);
    @(negedge clk);
    check("drain count", recv_n - r0, 9);
    for (int i = 0; i < 8; i++)
      check($sformatf("drain byte %0d", i), int'(recv_mem[r0 + i]), i);
    check("drain last byte", int'(recv_mem[r0 + 8]), 'hA5);
    check("drain level", int'(level), 0);

    // Randomized traffic with a randomly stalling consumer
    r0 = recv_n; f0 = fe_n; o0 = ov_n; bad = 0;
    exp_q.delete();
    rnd_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      b = 8'($urandom);
      s = ($urandom_range(0, 3) != 0);
      if (s) exp_q.push_back(b);
      else bad++;
      send_frame(b, s);
      repeat (30) @(posedge clk);
    end
    rnd_en = 1'b0;
    rdy_man = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("random count", recv_n - r0, exp_q.size());
    for (int i = 0; i < exp_q.size() && i < recv_n - r0; i++)
      check($sformatf("random byte %0d", i), int'(recv_mem[r0 + i]), int'(exp_q[i]));
    check("random frame_err", fe_n - f0, bad);
    check("random overrun", ov_n - o0, 0);

    // Reset mid-DATA of 0x3C with the line held low through release
    @(posedge clk); #1 ser = 1'b0;          // start, bit0, bit1 of 0x3C are all 0
    repeat (3 * BIT) @(posedge clk);
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    r0 = recv_n; f0 = fe_n; o0 = ov_n;
    @(negedge clk);
    check("midreset level", int'(level), 0);
    check("midreset rvalid", int'(rvalid), 0);
    repeat (3 * BIT) @(posedge clk);
    @(negedge clk);
    check("low-after-reset pushes", recv_n - r0, 0);
    check("low-after-reset frame_err", fe_n - f0, 0);
    check("low-after-reset overrun", ov_n - o0, 0);
    check("low-after-reset level", int'(level), 0);
    #1 ser = 1'b1;
    repeat (2 * BIT) @(posedge clk);
    send_frame(8'h3C, 1'b1);
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("post-reset pushes", recv_n - r0, 1);
    check("post-reset byte", int'(recv_mem[r0]), 'h3C);
    check("post-reset frame_err", fe_n - f0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
